// File: rtl/hif_fir_pkg.sv
// Shared types, default sizing and the output saturation helper for the HIF FIR MAC.
package hif_fir_pkg;

  localparam int unsigned NUM_TAPS_DEF = 1021;
  localparam int unsigned DW           = 16;
  localparam int unsigned ACC_W        = 42;
  localparam int unsigned SHIFT_DEF    = 15;

  typedef logic signed [DW-1:0]    sample_t;
  typedef logic signed [2*DW-1:0]  prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic {IDLE, RUN} state_e;

  // Address width that stays legal for a single-entry ROM.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp an already-scaled accumulator value into the signed sample range.
  function automatic sample_t sat16(input acc_t a);
    sample_t r;
    if (a > acc_t'(32767))       r = {1'b0, {(DW-1){1'b1}}};
    else if (a < acc_t'(-32768)) r = {1'b1, {(DW-1){1'b0}}};
    else                         r = a[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/hif_fir_mac_rom.sv
// Coefficient ROM: NUM_TAPS x DW, synchronous read with one cycle of latency.
module hif_coeff_rom
  import hif_fir_pkg::*;
#(
  parameter int unsigned                 NUM_TAPS = NUM_TAPS_DEF,
  parameter int unsigned                 AW       = addr_w(NUM_TAPS),
  parameter logic [NUM_TAPS*DW-1:0]      COEFFS   = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output sample_t       q
);

  // Registered read; tap i lives at bits [i*DW +: DW] of the image.
  always_ff @(posedge clk) begin
    q <= sample_t'(COEFFS[addr*DW +: DW]);
  end

endmodule

// File: rtl/hif_fir_mac.sv
// Burst FIR multiply-accumulate: one saturated output sample per queue burst.
module hif_fir_mac
  import hif_fir_pkg::*;
#(
  parameter int unsigned            NUM_TAPS = NUM_TAPS_DEF,
  parameter int unsigned            SHIFT    = SHIFT_DEF,
  parameter logic [NUM_TAPS*DW-1:0] COEFFS   = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    sequencing,
  input  sample_t smpl_in,
  output sample_t fir_out,
  output logic    fir_vld,
  output logic    tap_ovf,
  output logic    tap_short
);

  localparam int unsigned AW = addr_w(NUM_TAPS);
  localparam int unsigned CW = $clog2(NUM_TAPS + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           accept, start, end_burst, ovf_hit;
  logic [AW-1:0]  addr_d;

  logic           vld0, first0;
  logic [AW-1:0]  addr0;
  sample_t        smpl0;
  logic           vld1, first1, last1;
  sample_t        smpl1, coef1;
  logic           vld2, first2, last2;
  prod_t          prod2;
  acc_t           acc3;
  logic           last3;

  // Next-state and per-cycle burst decisions.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    start     = 1'b0;
    end_burst = 1'b0;
    ovf_hit   = 1'b0;
    addr_d    = '0;
    case (state_q)
      IDLE: begin
        if (sequencing) begin
          state_d = RUN;
          accept  = 1'b1;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (sequencing) begin
          if (cnt_q < CW'(NUM_TAPS)) begin
            accept = 1'b1;
            addr_d = cnt_q[AW-1:0];
          end else begin
            ovf_hit = 1'b1;
          end
        end else begin
          end_burst = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, tap counter and sticky burst-length flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tap_ovf   <= 1'b0;
      tap_short <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q     <= CW'(1);
        tap_ovf   <= 1'b0;
        tap_short <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (ovf_hit)   tap_ovf   <= 1'b1;
      if (end_burst) tap_short <= (cnt_q < CW'(NUM_TAPS));
    end
  end

  // E0: capture the accepted sample and its coefficient address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld0   <= 1'b0;
      first0 <= 1'b0;
      addr0  <= '0;
      smpl0  <= '0;
    end else begin
      vld0   <= accept;
      first0 <= start;
      if (accept) begin
        addr0 <= addr_d;
        smpl0 <= smpl_in;
      end
    end
  end

  hif_coeff_rom #(
    .NUM_TAPS (NUM_TAPS),
    .AW       (AW),
    .COEFFS   (COEFFS)
  ) u_rom (
    .clk  (clk),
    .addr (addr0),
    .q    (coef1)
  );

  // E1: sample delayed to meet ROM data. The end of a burst is only seen the
  // cycle after its final sample, so the last tag joins here, one stage late.
  // With an overlong burst it rides an empty slot, which is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1   <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      smpl1  <= '0;
    end else begin
      vld1   <= vld0;
      first1 <= first0;
      last1  <= end_burst;
      smpl1  <= smpl0;
    end
  end

  // E2: signed product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld2   <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      prod2  <= '0;
    end else begin
      vld2   <= vld1;
      first2 <= first1;
      last2  <= last1;
      if (vld1) prod2 <= smpl1 * coef1;
    end
  end

  // Accumulate; the first product of a burst reloads instead of adding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc3  <= '0;
      last3 <= 1'b0;
    end else begin
      last3 <= last2;
      if (vld2) acc3 <= first2 ? acc_t'(prod2) : acc3 + acc_t'(prod2);
    end
  end

  // Output register: scaled, saturated result with a one-cycle valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fir_out <= '0;
      fir_vld <= 1'b0;
    end else begin
      fir_vld <= last3;
      if (last3) fir_out <= sat16(acc3 >>> SHIFT);
    end
  end

endmodule

// File: tb/tb_hif_fir_mac.sv
// Scoreboard bench for hif_fir_mac: three instances (nominal, saturating, full-size).
module tb_hif_fir_mac;

  typedef struct {
    logic signed [15:0] val;
    int                 cyc;
    bit                 chk_flags;
    bit                 ovf;
    bit                 sht;
  } exp_t;

  function automatic int gen_c(input int i);
    int v;
    v = (i * 7919 + 12345) % 65536;
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic logic [1021*16-1:0] mk_c2();
    logic [1021*16-1:0] v;
    v = '0;
    for (int i = 0; i < 1021; i++) v[i*16 +: 16] = 16'(gen_c(i));
    return v;
  endfunction

  localparam logic [4*16-1:0]    C0 = {16'h0800, 16'h1000, 16'h2000, 16'h4000};
  localparam logic [4*16-1:0]    C1 = {4{16'h7FFF}};
  localparam logic [1021*16-1:0] C2 = mk_c2();

  int c0_tab [4] = '{16384, 8192, 4096, 2048};

  logic clk, rst_n;
  logic seq [3];
  logic signed [15:0] smp [3];
  logic signed [15:0] fo  [3];
  logic fv [3], ovf [3], sht [3];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q0[$], q1[$], q2[$];
  logic signed [15:0] sbuf[$];
  logic signed [15:0] last_val [3];

  hif_fir_mac #(.NUM_TAPS(4), .SHIFT(15), .COEFFS(C0)) u0 (
    .clk(clk), .rst_n(rst_n), .sequencing(seq[0]), .smpl_in(smp[0]),
    .fir_out(fo[0]), .fir_vld(fv[0]), .tap_ovf(ovf[0]), .tap_short(sht[0]));

  hif_fir_mac #(.NUM_TAPS(4), .SHIFT(15), .COEFFS(C1)) u1 (
    .clk(clk), .rst_n(rst_n), .sequencing(seq[1]), .smpl_in(smp[1]),
    .fir_out(fo[1]), .fir_vld(fv[1]), .tap_ovf(ovf[1]), .tap_short(sht[1]));

  hif_fir_mac #(.COEFFS(C2)) u2 (
    .clk(clk), .rst_n(rst_n), .sequencing(seq[2]), .smpl_in(smp[2]),
    .fir_out(fo[2]), .fir_vld(fv[2]), .tap_ovf(ovf[2]), .tap_short(sht[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int taps(input int d);
    return (d == 2) ? 1021 : 4;
  endfunction

  function automatic int coef(input int d, input int i);
    case (d)
      0:       return c0_tab[i];
      1:       return 32767;
      default: return gen_c(i);
    endcase
  endfunction

  function automatic logic signed [15:0] sat(input longint a);
    if (a > 32767)  return 16'sh7FFF;
    if (a < -32768) return 16'sh8000;
    return 16'(a);
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop_exp(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d exp=%0d @cyc %0d", nm, d, act, exp, cyc);
    end
  endtask

  // Drive sbuf as one burst on DUT d, then hold sequencing low for gap cycles.
  task automatic run_burst(input int d, input int gap);
    longint acc;
    int     n, nt;
    exp_t   e;
    acc = 0;
    n   = sbuf.size();
    nt  = taps(d);
    for (int i = 0; i < n && i < nt; i++) acc += longint'(sbuf[i]) * coef(d, i);
    e.val       = sat(acc >>> 15);
    e.ovf       = (n > nt);
    e.sht       = (n < nt);
    e.chk_flags = (gap >= 4);
    for (int i = 0; i < n; i++) begin
      seq[d] = 1'b1;
      smp[d] = sbuf[i];
      @(posedge clk); #1;
    end
    seq[d] = 1'b0;
    smp[d] = 16'($urandom);
    e.cyc  = cyc + 4;
    push_exp(d, e);
    last_val[d] = e.val;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fill(input int n, input logic signed [15:0] v);
    sbuf.delete();
    for (int i = 0; i < n; i++) sbuf.push_back(v);
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 60 && (qsize(0) + qsize(1) + qsize(2)) > 0; i++) begin
      @(posedge clk); #1;
    end
    left = qsize(0) + qsize(1) + qsize(2);
    chk("drain", 0, left, 0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (fv[d]) begin
          if (qsize(d) == 0) begin
            chk("spurious_vld", d, 1, 0);
          end else begin
            exp_t e;
            e = pop_exp(d);
            chk("fir_out", d, fo[d], e.val);
            chk("latency", d, cyc, e.cyc);
            if (e.chk_flags) begin
              chk("tap_ovf", d, ovf[d], e.ovf);
              chk("tap_short", d, sht[d], e.sht);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      seq[d] = 1'b0;
      smp[d] = '0;
      last_val[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_fir_out", d, fo[d], 0);
      chk("rst_fir_vld", d, fv[d], 0);
      chk("rst_tap_ovf", d, ovf[d], 0);
      chk("rst_tap_short", d, sht[d], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    fill(4, 16'sh1000); run_burst(0, 6);
    fill(4, 16'sh7FFF); run_burst(1, 6);
    fill(4, 16'sh8000); run_burst(1, 6);
    fill(2, 16'sh1000); run_burst(0, 6);
    fill(6, 16'sh1000); run_burst(0, 6);
    fill(4, 16'sh1000); run_burst(0, 1);
    fill(4, 16'sh2000); run_burst(0, 6);
    fill(1, 16'sh1234); run_burst(0, 6);

    // Random bursts of random length and gap
    for (int b = 0; b < 40; b++) begin
      sbuf.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) sbuf.push_back(16'($urandom));
      run_burst(b % 2, $urandom_range(1, 6));
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_fir_out", 0, fo[0], last_val[0]);
    chk("hold_fir_out", 1, fo[1], last_val[1]);

    // Reset in the middle of a burst: nothing may emerge from it
    fill(4, 16'sh1000); run_burst(0, 6);
    drain();
    seq[0] = 1'b1; smp[0] = 16'sh1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    seq[0] = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk("midrst_fir_out", 0, fo[0], 0);
    chk("midrst_fir_vld", 0, fv[0], 0);
    chk("midrst_tap_ovf", 0, ovf[0], 0);
    chk("midrst_tap_short", 0, sht[0], 0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_quiet_out", 0, fo[0], 0);
    fill(4, 16'sh1000); run_burst(0, 6);

    // Full-size impulse responses
    for (int j = 0; j < 3; j++) begin
      int k;
      k = (j == 0) ? 0 : (j == 1) ? 510 : 1020;
      fill(1021, 16'sh0000);
      sbuf[k] = 16'sh7FFF;
      run_burst(2, 6);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog dut0 got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
